// File: rtl/konwerter_bcd_pkg.sv
// Shared types and elaboration-time helpers for the sequential binary-to-BCD converter.
// Holds the FSM state encoding and the constant functions used to size internal registers.
package konwerter_bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } stan_t;

    // Number of decimal digits needed for the largest value of a 'bits'-wide unsigned number.
    function automatic int clog10(input int bits);
        logic [63:0] v;
        int          n;
        v = (bits >= 64) ? '1 : ((64'd1 << bits) - 64'd1);
        n = 1;
        while (v >= 64'd10) begin
            v = v / 64'd10;
            n++;
        end
        return n;
    endfunction

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    function automatic int cnt_width(input int refresh);
        return (refresh <= 2) ? 1 : $clog2(refresh);
    endfunction

endpackage

// File: rtl/konwerter_bcd_licznik_odswiezania.sv
// Free-running refresh counter 0..REFRESH-1; tick is high in the cycle where the count
// sits at its last value, so the conversion is triggered on the wrapping edge.
module licznik_odswiezania
    import konwerter_bcd_pkg::*;
#(
    parameter int REFRESH = 10000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int            CW   = cnt_width(REFRESH);
    localparam logic [CW-1:0] LAST = CW'(REFRESH - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/konwerter_bcd.sv
// Sequential shift-add-3 binary-to-BCD converter, one input bit per clock, with saturation
// to all nines on overflow and leading-zero blanking flags for the 7-segment driver.
module konwerter_bcd
    import konwerter_bcd_pkg::*;
#(
    parameter int BIN_W   = 7,
    parameter int DIGITS  = 2,
    parameter int REFRESH = 10000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [BIN_W-1:0]      bin_in,
    input  logic                  start,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     blank,
    output logic                  ovf,
    output logic                  busy,
    output logic                  valid
);

    // State table
    //   ST_IDLE  | waiting for start, refresh tick or a pending tick
    //   ST_SHIFT | BIN_W add-3/shift steps, bit counter BIN_W-1 down to 0
    //   ST_DONE  | publish result, pulse valid, drop busy

    localparam int                 INT_DIGITS   = clog10(BIN_W);
    localparam int                 ACC_W        = 4 * INT_DIGITS;
    localparam int                 OUT_W        = 4 * DIGITS;
    localparam int                 BC_W         = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam bit                 OVF_POSSIBLE = (DIGITS < INT_DIGITS);
    // Only meaningful when OVF_POSSIBLE, in which case it fits in BIN_W bits.
    localparam logic [BIN_W-1:0]   MAX_DEC      = BIN_W'(pow10(DIGITS) - 64'd1);
    localparam logic [DIGITS-1:0]  BLANK_RST    = {DIGITS{1'b1}} ^ DIGITS'(1);

    logic tick;

    generate
        if (REFRESH != 0) begin : g_refresh
            licznik_odswiezania #(
                .REFRESH (REFRESH)
            ) u_licznik (
                .clk   (clk),
                .rst_n (rst_n),
                .tick  (tick)
            );
        end else begin : g_no_refresh
            assign tick = 1'b0;
        end
    endgenerate

    stan_t               state_q, state_d;
    logic [BIN_W-1:0]    sh_q, sh_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [ACC_W-1:0]    adj;
    logic [BC_W-1:0]     bc_q, bc_d;
    logic                ovf_nxt_q, ovf_nxt_d;
    logic                pending_q, pending_d;
    logic [OUT_W-1:0]    bcd_q, bcd_d;
    logic [DIGITS-1:0]   blank_q, blank_d;
    logic                ovf_q, ovf_d;
    logic                busy_q, busy_d;
    logic                valid_q, valid_d;
    logic                trigger;
    logic                accept;
    logic                zero_above;

    assign trigger = start | tick | pending_q;
    assign accept  = (state_q == ST_IDLE) && trigger;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (trigger) state_d = ST_SHIFT;
            ST_SHIFT: if (bc_q == '0) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sh_d       = sh_q;
        acc_d      = acc_q;
        adj        = acc_q;
        bc_d       = bc_q;
        ovf_nxt_d  = ovf_nxt_q;
        bcd_d      = bcd_q;
        blank_d    = blank_q;
        ovf_d      = ovf_q;
        busy_d     = busy_q;
        valid_d    = 1'b0;
        zero_above = 1'b1;

        // A tick that arrives while a conversion is running is remembered once.
        if (accept) begin
            pending_d = 1'b0;
        end else if (tick && (state_q != ST_IDLE)) begin
            pending_d = 1'b1;
        end else begin
            pending_d = pending_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    sh_d      = bin_in;
                    acc_d     = '0;
                    bc_d      = BC_W'(BIN_W - 1);
                    ovf_nxt_d = OVF_POSSIBLE && (bin_in > MAX_DEC);
                    busy_d    = 1'b1;
                end
            end
            ST_SHIFT: begin
                for (int i = 0; i < INT_DIGITS; i++) begin
                    if (acc_q[4*i +: 4] >= 4'd5) begin
                        adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
                    end
                end
                {acc_d, sh_d} = {adj, sh_q} << 1;
                bc_d          = bc_q - BC_W'(1);
            end
            ST_DONE: begin
                bcd_d   = ovf_nxt_q ? {DIGITS{4'h9}} : OUT_W'(acc_q);
                ovf_d   = ovf_nxt_q;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                blank_d = '0;
                for (int k = DIGITS - 1; k >= 1; k--) begin
                    zero_above = zero_above && (bcd_d[4*k +: 4] == 4'h0);
                    blank_d[k] = zero_above && !ovf_nxt_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q      <= '0;
            acc_q     <= '0;
            bc_q      <= '0;
            ovf_nxt_q <= 1'b0;
            pending_q <= 1'b0;
            bcd_q     <= '0;
            blank_q   <= BLANK_RST;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            sh_q      <= sh_d;
            acc_q     <= acc_d;
            bc_q      <= bc_d;
            ovf_nxt_q <= ovf_nxt_d;
            pending_q <= pending_d;
            bcd_q     <= bcd_d;
            blank_q   <= blank_d;
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
        end
    end

    assign bcd_out = bcd_q;
    assign blank   = blank_q;
    assign ovf     = ovf_q;
    assign busy    = busy_q;
    assign valid   = valid_q;

endmodule

// File: tb/tb_konwerter_bcd.sv
// Bench for konwerter_bcd: three configurations (start-only 7b/2d, refresh 7b/2d, 14b/4d)
// checked against a decimal-arithmetic reference model.
module tb_konwerter_bcd;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [6:0]  bin0, bin1;
    logic        start0, start1;
    logic [7:0]  bcd0, bcd1;
    logic [1:0]  blank0, blank1;
    logic        ovf0, ovf1, busy0, busy1, valid0, valid1;
    logic [13:0] bin2;
    logic        start2;
    logic [15:0] bcd2;
    logic [3:0]  blank2;
    logic        ovf2, busy2, valid2;

    int errors = 0;
    int checks = 0;

    konwerter_bcd #(.BIN_W(7), .DIGITS(2), .REFRESH(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bin_in(bin0), .start(start0), .bcd_out(bcd0),
        .blank(blank0), .ovf(ovf0), .busy(busy0), .valid(valid0));

    konwerter_bcd #(.BIN_W(7), .DIGITS(2), .REFRESH(20)) dut1 (
        .clk(clk), .rst_n(rst_n), .bin_in(bin1), .start(start1), .bcd_out(bcd1),
        .blank(blank1), .ovf(ovf1), .busy(busy1), .valid(valid1));

    konwerter_bcd #(.BIN_W(14), .DIGITS(4), .REFRESH(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .bin_in(bin2), .start(start2), .bcd_out(bcd2),
        .blank(blank2), .ovf(ovf2), .busy(busy2), .valid(valid2));

    function automatic int p10(input int n);
        int r = 1;
        repeat (n) r = r * 10;
        return r;
    endfunction

    function automatic logic m_ovf(input int v, input int d);
        return v > p10(d) - 1;
    endfunction

    function automatic logic [15:0] m_bcd(input int v, input int d);
        logic [15:0] r = '0;
        int          s;
        s = m_ovf(v, d) ? p10(d) - 1 : v;
        for (int k = 0; k < d; k++) r[4*k +: 4] = 4'((s / p10(k)) % 10);
        return r;
    endfunction

    function automatic logic [3:0] m_blank(input int v, input int d);
        logic [3:0] r = '0;
        if (!m_ovf(v, d))
            for (int k = 1; k < d; k++) r[k] = (v < p10(k));
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic smp(input int which, output logic [15:0] b, output logic [3:0] bl,
                       output logic o, output logic bs, output logic vl);
        case (which)
            0:       begin b = {8'h0, bcd0}; bl = {2'b0, blank0}; o = ovf0; bs = busy0; vl = valid0; end
            1:       begin b = {8'h0, bcd1}; bl = {2'b0, blank1}; o = ovf1; bs = busy1; vl = valid1; end
            default: begin b = bcd2; bl = blank2; o = ovf2; bs = busy2; vl = valid2; end
        endcase
    endtask

    task automatic wait_v(input int which, input int maxc, output int n);
        logic [15:0] b;
        logic [3:0]  bl;
        logic        o, bs, vl;
        n = 0;
        while (n < maxc) begin
            @(posedge clk); #1;
            n++;
            smp(which, b, bl, o, bs, vl);
            if (vl) break;
        end
    endtask

    task automatic run(input int which, input int v, input string tag);
        logic [15:0] b;
        logic [3:0]  bl;
        logic        o, bs, vl;
        int          n, bc, d, lat;
        d   = (which == 2) ? 4 : 2;
        lat = (which == 2) ? 15 : 8;
        case (which)
            0:       begin bin0 = 7'(v);  start0 = 1'b1; end
            1:       begin bin1 = 7'(v);  start1 = 1'b1; end
            default: begin bin2 = 14'(v); start2 = 1'b1; end
        endcase
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        smp(which, b, bl, o, bs, vl);
        bc = bs ? 1 : 0;
        n  = 0;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            smp(which, b, bl, o, bs, vl);
            if (vl) break;
            if (bs) bc++;
        end
        chk({tag, ".latency"}, n, lat);
        chk({tag, ".busy_cycles"}, bc, lat);
        chk({tag, ".bcd"}, b, m_bcd(v, d));
        chk({tag, ".blank"}, bl, m_blank(v, d));
        chk({tag, ".ovf"}, o, m_ovf(v, d));
        @(posedge clk); #1;
        smp(which, b, bl, o, bs, vl);
        chk({tag, ".valid_pulse"}, vl, 1'b0);
    endtask

    initial begin
        int cnt, n, a, bv;
        logic [7:0] last;

        rst_n = 1'b1;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        bin0 = '0; bin1 = '0; bin2 = '0;
        #3 rst_n = 1'b0;
        #4;
        chk("rst.bcd0", bcd0, 8'h00);
        chk("rst.blank0", blank0, 2'b10);
        chk("rst.flags0", {ovf0, busy0, valid0}, 3'b000);
        chk("rst.bcd2", bcd2, 16'h0000);
        chk("rst.blank2", blank2, 4'b1110);
        chk("rst.flags1", {ovf1, busy1, valid1}, 3'b000);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        cnt = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (valid0 || busy0) cnt++;
        end
        chk("idle.no_activity", cnt, 0);

        run(0, 87, "d87");
        run(0, 5, "d5");
        run(0, 0, "d0");
        run(0, 127, "d127");
        for (int i = 0; i < 128; i++) run(0, i, $sformatf("exh%0d", i));

        // Extra start and a changed bin_in while busy must not disturb the running result.
        bin0 = 7'd33; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        bin0 = 7'd99; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        cnt = 0; last = '0;
        repeat (25) begin
            @(posedge clk); #1;
            if (valid0) begin cnt++; last = bcd0; end
        end
        chk("drop.valid_count", cnt, 1);
        chk("drop.result", last, 8'h33);

        run(2, 9999, "w9999");
        run(2, 10000, "w10000");
        run(2, 42, "w42");
        run(2, 0, "w0");
        repeat (25) run(2, int'($urandom_range(0, 16383)), "wrand");

        bin1 = 7'($urandom_range(0, 127));
        wait_v(1, 60, n);
        chk("ref.sync_valid", valid1, 1'b1);
        repeat (4) begin
            bin1 = 7'($urandom_range(0, 127));
            wait_v(1, 40, n);
            chk("ref.period", n, 20);
            chk("ref.bcd", bcd1, m_bcd(int'(bin1), 2));
            chk("ref.blank", blank1, m_blank(int'(bin1), 2));
            chk("ref.ovf", ovf1, m_ovf(int'(bin1), 2));
        end

        // Start shortly after a refresh result so the next tick lands mid-conversion.
        a  = int'($urandom_range(0, 127));
        bv = int'($urandom_range(10, 127));
        repeat (4) begin @(posedge clk); #1; end
        bin1 = 7'(a); start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; bin1 = 7'(bv);
        wait_v(1, 40, n);
        chk("pend.first_latency", n, 8);
        chk("pend.first_bcd", bcd1, m_bcd(a, 2));
        wait_v(1, 40, n);
        chk("pend.second_gap", n, 9);
        chk("pend.second_bcd", bcd1, m_bcd(bv, 2));

        n = 0;
        while (!busy1 && n < 40) begin @(posedge clk); #1; n++; end
        repeat (2) begin @(posedge clk); #1; end
        chk("abort.in_progress", busy1, 1'b1);
        rst_n = 1'b0;
        #2;
        chk("abort.bcd", bcd1, 8'h00);
        chk("abort.blank", blank1, 2'b10);
        chk("abort.flags", {ovf1, busy1, valid1}, 3'b000);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        cnt = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (valid1) cnt++;
        end
        chk("abort.no_valid", cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
